fir_out_buffer: RTL and testbench
=================================

Name: fir_out_buffer

Overview:
- Downstream stage of the FIR tap chain.
- Captures the final chain sum, which is the ov_sum of the last tap, on every sample strobe.
- Records overflow status and buffers samples in a small synchronous FIFO.
- Presents samples to the consumer over a valid/ready handshake, so back-pressure never stalls the tap chain. Samples that cannot be stored are dropped and flagged.

Parameters:
- DATA_WIDTH, 24: width of the signed chain sum and output sample. Must match the tap chain.
- DEPTH, 4: FIFO entries. Must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH): pointer width. Derived; do not override.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  sample strobe; the same strobe that drives the taps' i_en.
- iv_sum  in  DATA_WIDTH  signed final chain sum.
- i_prod_overflow  in  1  OR of all taps' o_prod_overflow.
- i_sum_overflow  in  1  OR of all taps' o_sum_overflow.
- ov_dout  out  DATA_WIDTH  signed head-of-FIFO sample.
- o_valid  out  1  ov_dout holds a valid sample.
- i_ready  in  1  consumer accepts the sample.
- o_full  out  1  FIFO count == DEPTH.
- o_empty  out  1  FIFO count == 0.
- o_drop  out  1  one-cycle pulse: the sample was lost.
- o_sticky_prod_ovf  out  1  latched product overflow.
- o_sticky_sum_ovf  out  1  latched sum overflow.
- o_sticky_drop  out  1  latched drop.
- i_clr_flags  in  1  clears all sticky flags.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high via i_rst.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, all sticky flags 0, o_drop=0. Memory contents are not reset.
- Output qualification: o_valid=(count!=0). o_empty=(count==0). o_full=(count==DEPTH).
- ov_dout: equals mem[rd_ptr] when o_valid=1, and is forced to 0 when empty. It must read 0 immediately after reset.
- Push: i_en=1 and (count<DEPTH or pop in the same cycle). Writes iv_sum to mem[wr_ptr], then wr_ptr increments.
- Pop: o_valid && i_ready. rd_ptr increments.
- Pointer wrap: pointers wrap modulo DEPTH (natural PTR_W rollover).
- Count update: count +1 on push only, −1 on pop only, unchanged when both occur.
- Latency: a sample pushed in cycle N is visible on ov_dout with o_valid=1 in cycle N+1 when the FIFO was empty. There is no combinational path from iv_sum or i_en to ov_dout or o_valid.
- Full boundary: if i_en=1 while full and no pop occurs, the sample is discarded, o_drop=1 for exactly that cycle, and o_sticky_drop is set. If full with a simultaneous pop, the push succeeds and count stays DEPTH.
- Empty boundary: i_ready while empty has no effect, and pointers do not move.
- Ready while invalid: the consumer may hold i_ready high at any time.
- Handshake stability: once o_valid=1, ov_dout is stable until popped. The block never withdraws o_valid without a pop, except on reset.
- Sticky flags: on each i_en cycle, o_sticky_prod_ovf |= i_prod_overflow and o_sticky_sum_ovf |= i_sum_overflow. Flags are sampled even when the sample is dropped.
- Flag clear: i_clr_flags=1 clears all three sticky flags. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: buffered samples are discarded, o_valid falls in the cycle after the reset edge, and flags clear.

Optional Feature:
- Macro: FIR_OUT_OVF_TAG_EN.
- Defined:
  - Each FIFO entry stores an extra tag bit = i_prod_overflow | i_sum_overflow, captured with the sample.
  - Adds output port o_ovf_tag (1 bit), aligned with ov_dout, 0 when empty.
- Undefined: no tag storage and no o_ovf_tag port. All other behaviour is identical.

Decomposition:
- Package fir_pkg:
  - DATA_WIDTH default.
  - MIN_VALUE = −2**(DATA_WIDTH−1) and MAX_VALUE = 2**(DATA_WIDTH−1)−1, shared with the taps.
  - A sample typedef (signed DATA_WIDTH).
- Sub-module sync_fifo (parameters WIDTH, DEPTH): pointers, count, memory, and push/pop/full/empty logic.
- fir_out_buffer wraps sync_fifo and adds the sticky-flag and drop logic. With FIR_OUT_OVF_TAG_EN, the FIFO WIDTH becomes DATA_WIDTH+1.

Test Plan:
- Reset then idle → o_empty=1, o_valid=0, ov_dout=0, all flags 0.
- i_en with iv_sum=0x000123, i_ready=1 → next cycle ov_dout=0x000123, o_valid=1; popped that cycle; o_empty=1 after.
- i_ready=0; push 0xFFFFF0, 0x000001, 0x7FFFFF, 0x800000 → o_full=1. A 5th push of 0x000055 gives o_drop=1 for one cycle and o_sticky_drop=1. Draining then yields exactly those 4 values in order.
- Full, i_en=1 with iv_sum=0x0000AA and i_ready=1 in the same cycle → no drop, count stays 4, 0x0000AA is the last value drained.
- i_en with i_sum_overflow=1 → o_sticky_sum_ovf=1 persists. i_clr_flags=1 with a new overflow in the same cycle → flag stays 1. A clear with no overflow → 0.
- Push 3 samples, assert i_rst for 1 cycle mid-drain → o_valid=0, o_empty=1, ov_dout=0 after; the next push round-trips correctly from pointer 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR types and constants for the tap chain and the output buffer.
package fir_pkg;

  localparam int DATA_WIDTH = 24;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  localparam sample_t MIN_VALUE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam sample_t MAX_VALUE = {1'b0, {(DATA_WIDTH-1){1'b1}}};

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: push on i_wr when not full (or popping), pop on i_rd when not empty.
// Latency 1 cycle write-to-head; a rejected write is reported on o_wr_reject, never stalled.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] iv_din,
  input  logic             i_rd,
  output logic [WIDTH-1:0] ov_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_wr_reject
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  assign o_empty     = (count == '0);
  assign o_full      = (count == (PTR_W+1)'(DEPTH));
  assign pop         = i_rd && !o_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push        = i_wr && (!o_full || pop);
  assign o_wr_reject = i_wr && !push;
  assign ov_dout     = o_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= iv_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_buffer.sv
// FIR output buffer: captures the chain sum per strobe into a FIFO, latches overflow/drop flags.
// Latency 1 cycle to ov_dout; back-pressure never stalls the chain, overflow drops and pulses o_drop.
// Optional FIR_OUT_OVF_TAG_EN stores a per-sample overflow tag and exposes o_ovf_tag.
module fir_out_buffer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] iv_sum,
  input  logic                         i_prod_overflow,
  input  logic                         i_sum_overflow,
  output logic signed [DATA_WIDTH-1:0] ov_dout,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_drop,
  output logic                         o_sticky_prod_ovf,
  output logic                         o_sticky_sum_ovf,
  output logic                         o_sticky_drop,
`ifdef FIR_OUT_OVF_TAG_EN
  output logic                         o_ovf_tag,
`endif
  input  logic                         i_clr_flags
);

`ifdef FIR_OUT_OVF_TAG_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_dout;
  logic          wr_reject;

`ifdef FIR_OUT_OVF_TAG_EN
  assign fifo_din  = {i_prod_overflow | i_sum_overflow, iv_sum};
  assign o_ovf_tag = fifo_dout[DATA_WIDTH];
`else
  assign fifo_din  = iv_sum;
`endif
  assign ov_dout = fifo_dout[DATA_WIDTH-1:0];
  assign o_valid = !o_empty;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr        (i_en),
    .iv_din      (fifo_din),
    .i_rd        (i_ready),
    .ov_dout     (fifo_dout),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_wr_reject (wr_reject)
  );

  // Clear first, then OR in new events so a same-cycle set wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_drop            <= 1'b0;
      o_sticky_prod_ovf <= 1'b0;
      o_sticky_sum_ovf  <= 1'b0;
      o_sticky_drop     <= 1'b0;
    end else begin
      o_drop            <= wr_reject;
      o_sticky_prod_ovf <= (o_sticky_prod_ovf && !i_clr_flags) || (i_en && i_prod_overflow);
      o_sticky_sum_ovf  <= (o_sticky_sum_ovf && !i_clr_flags) || (i_en && i_sum_overflow);
      o_sticky_drop     <= (o_sticky_drop && !i_clr_flags) || wr_reject;
    end
  end

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed bench for fir_out_buffer (default build, 24-bit samples, depth 4).
module tb_fir_out_buffer;

  logic        clk = 1'b0;
  logic        rst, en, prod_ovf, sum_ovf, ready, clr;
  logic [23:0] sum;
  logic [23:0] dout;
  logic        valid, full, empty, drop, s_prod, s_sum, s_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_out_buffer dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_en              (en),
    .iv_sum            (sum),
    .i_prod_overflow   (prod_ovf),
    .i_sum_overflow    (sum_ovf),
    .ov_dout           (dout),
    .o_valid           (valid),
    .i_ready           (ready),
    .o_full            (full),
    .o_empty           (empty),
    .o_drop            (drop),
    .o_sticky_prod_ovf (s_prod),
    .o_sticky_sum_ovf  (s_sum),
    .o_sticky_drop     (s_drop),
    .i_clr_flags       (clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] v);
    en  = 1'b1;
    sum = v;
    tick();
    en  = 1'b0;
  endtask

  logic [23:0] fill_vals [4] = '{24'hFFFFF0, 24'h000001, 24'h7FFFFF, 24'h800000};
  logic [23:0] pass_vals [4] = '{24'h000002, 24'h000003, 24'h000004, 24'h0000AA};

  initial begin
    rst = 1'b1; en = 1'b0; sum = '0; prod_ovf = 1'b0; sum_ovf = 1'b0;
    ready = 1'b0; clr = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset / idle state
    check("rst_empty", {31'b0, empty}, 1);
    check("rst_valid", {31'b0, valid}, 0);
    check("rst_dout",  {8'b0, dout}, 0);
    check("rst_full",  {31'b0, full}, 0);
    check("rst_flags", {28'b0, drop, s_prod, s_sum, s_drop}, 0);

    // Single sample round trip with ready held high
    ready = 1'b1;
    push(24'h000123);
    check("rt_valid", {31'b0, valid}, 1);
    check("rt_dout",  {8'b0, dout}, 32'h000123);
    tick();
    check("rt_empty", {31'b0, empty}, 1);
    check("rt_dout0", {8'b0, dout}, 0);

    // Ready while empty: nothing moves
    tick(); tick();
    check("idle_rdy_valid", {31'b0, valid}, 0);

    // Fill to full, then overflow drop
    ready = 1'b0;
    for (int i = 0; i < 4; i++) push(fill_vals[i]);
    check("fill_full",  {31'b0, full}, 1);
    check("fill_head",  {8'b0, dout}, 32'hFFFFF0);
    check("fill_nodrop", {31'b0, drop}, 0);
    push(24'h000055);
    check("drop_pulse",  {31'b0, drop}, 1);
    check("drop_sticky", {31'b0, s_drop}, 1);
    check("drop_full",   {31'b0, full}, 1);
    tick();
    check("drop_end",    {31'b0, drop}, 0);
    check("drop_keep",   {31'b0, s_drop}, 1);
    check("drop_head",   {8'b0, dout}, 32'hFFFFF0);

    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), {8'b0, dout}, {8'b0, fill_vals[i]});
      tick();
    end
    check("drain_empty", {31'b0, empty}, 1);

    // Full with simultaneous push and pop
    ready = 1'b0;
    push(24'h000001);
    push(24'h000002);
    push(24'h000003);
    push(24'h000004);
    en = 1'b1; sum = 24'h0000AA; ready = 1'b1;
    tick();
    en = 1'b0;
    check("pp_full",   {31'b0, full}, 1);
    check("pp_nodrop", {31'b0, drop}, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp_drain_%0d", i), {8'b0, dout}, {8'b0, pass_vals[i]});
      tick();
    end
    check("pp_empty", {31'b0, empty}, 1);

    // Sticky flags: set, persist, set-wins-over-clear, clear
    ready = 1'b1;
    prod_ovf = 1'b1;
    tick();
    check("prod_no_en", {31'b0, s_prod}, 0);
    prod_ovf = 1'b0;
    sum_ovf = 1'b1;
    push(24'h000000);
    sum_ovf = 1'b0;
    check("sum_set",  {31'b0, s_sum}, 1);
    check("prod_clr", {31'b0, s_prod}, 0);
    tick();
    check("sum_hold", {31'b0, s_sum}, 1);
    prod_ovf = 1'b1;
    push(24'h000000);
    prod_ovf = 1'b0;
    check("prod_set", {31'b0, s_prod}, 1);
    clr = 1'b1; sum_ovf = 1'b1;
    push(24'h000000);
    sum_ovf = 1'b0;
    check("clr_setwins", {31'b0, s_sum}, 1);
    check("clr_prod",    {31'b0, s_prod}, 0);
    check("clr_drop",    {31'b0, s_drop}, 0);
    tick();
    clr = 1'b0;
    check("clr_sum", {31'b0, s_sum}, 0);

    // Reset mid-drain, then round trip from pointer 0
    tick(); tick();
    ready = 1'b0;
    push(24'h000111);
    push(24'h000222);
    push(24'h000333);
    ready = 1'b1;
    tick();
    check("mid_head", {8'b0, dout}, 32'h000222);
    rst = 1'b1; ready = 1'b0;
    tick();
    rst = 1'b0;
    check("mrst_valid", {31'b0, valid}, 0);
    check("mrst_empty", {31'b0, empty}, 1);
    check("mrst_dout",  {8'b0, dout}, 0);
    push(24'h000444);
    check("post_valid", {31'b0, valid}, 1);
    check("post_dout",  {8'b0, dout}, 32'h000444);
    ready = 1'b1;
    tick();
    check("post_empty", {31'b0, empty}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
